// File: rtl/conv_window_mac_if.sv
// Row-beat input and result-output handshake bundle for conv_window_mac.
// The master side feeds rows and accepts results; the engine takes the slave side.
interface conv_window_mac_if #(
    parameter int DATA_W = 8,
    parameter int K      = 4,
    parameter int OUT_W  = 25
);
    logic                  in_valid;
    logic                  in_ready;
    logic [K*DATA_W-1:0]   in_data;
    logic [K*DATA_W-1:0]   in_kern;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_result;
    logic                  out_sat;

    modport master (
        output in_valid, in_data, in_kern, out_ready,
        input  in_ready, out_valid, out_result, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_kern, out_ready,
        output in_ready, out_valid, out_result, out_sat
    );
endinterface

// File: rtl/conv_window_mac.sv
// K x K windowed multiply-accumulate: one data/kernel row per beat, K beats per window,
// result optionally ReLU-clamped and saturated into a valid/ready output register.
module conv_window_mac #(
    parameter int DATA_W      = 8,
    parameter int K           = 4,
    parameter int OUT_W       = 25,
    parameter int SIGNED_MODE = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           relu_en,
    conv_window_mac_if.slave bus
);
    localparam int ACC_W = 2*DATA_W + $clog2(K*K) + 1;
    localparam int CNT_W = $clog2(K);
    // Comparison width leaves headroom so the clamp limits never wrap.
    localparam int CW    = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 2;
    localparam logic [CNT_W-1:0]     LAST_ROW = CNT_W'(K-1);
    localparam logic signed [CW-1:0] ONE      = CW'(1);
    localparam logic signed [CW-1:0] MAX_V    = (SIGNED_MODE != 0) ? (ONE <<< (OUT_W-1)) - ONE
                                                                   : (ONE <<< OUT_W) - ONE;
    localparam logic signed [CW-1:0] MIN_V    = (SIGNED_MODE != 0) ? -(ONE <<< (OUT_W-1)) : '0;

    logic [CNT_W-1:0]  row_cnt_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic              relu_q_reg;
    logic              out_valid_reg;
    logic [OUT_W-1:0]  out_result_reg;
    logic              out_sat_reg;

    logic [ACC_W-1:0]  prod [K];
    logic [ACC_W-1:0]  row_sum;
    logic [ACC_W-1:0]  final_sum;
    logic signed [CW-1:0] final_ext;
    logic [OUT_W-1:0]  load_val;
    logic              load_sat;
    logic              in_ready_int;
    logic              accept;
    logic              last_row;

    // Operands are widened to ACC_W before multiplying; the truncated product is
    // exact in two's complement because the true row sum fits in ACC_W bits.
    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_mul
            logic [DATA_W-1:0] d_el;
            logic [DATA_W-1:0] k_el;
            logic              d_sb;
            logic              k_sb;
            logic [ACC_W-1:0]  d_ext;
            logic [ACC_W-1:0]  k_ext;
            assign d_el  = bus.in_data[gi*DATA_W +: DATA_W];
            assign k_el  = bus.in_kern[gi*DATA_W +: DATA_W];
            assign d_sb  = (SIGNED_MODE != 0) && d_el[DATA_W-1];
            assign k_sb  = (SIGNED_MODE != 0) && k_el[DATA_W-1];
            assign d_ext = {{(ACC_W-DATA_W){d_sb}}, d_el};
            assign k_ext = {{(ACC_W-DATA_W){k_sb}}, k_el};
            assign prod[gi] = d_ext * k_ext;
        end
    endgenerate

    always_comb begin
        row_sum = '0;
        for (int j = 0; j < K; j++) begin
            row_sum = row_sum + prod[j];
        end
    end

    assign final_sum = acc_reg + row_sum;
    assign final_ext = {{(CW-ACC_W){(SIGNED_MODE != 0) && final_sum[ACC_W-1]}}, final_sum};

    always_comb begin
        load_val = final_ext[OUT_W-1:0];
        load_sat = 1'b0;
        if (relu_q_reg && (SIGNED_MODE != 0) && (final_ext < 0)) begin
            load_val = '0;
        end else if (final_ext > MAX_V) begin
            load_val = MAX_V[OUT_W-1:0];
            load_sat = 1'b1;
        end else if (final_ext < MIN_V) begin
            load_val = MIN_V[OUT_W-1:0];
            load_sat = 1'b1;
        end
    end

    // Only the completing row waits for a held result; a flush cycle refuses every beat.
    assign last_row     = (row_cnt_reg == LAST_ROW);
    assign in_ready_int = !flush && !(last_row && out_valid_reg && !bus.out_ready);
    assign accept       = bus.in_valid && in_ready_int;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_cnt_reg    <= '0;
            acc_reg        <= '0;
            relu_q_reg     <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
            out_sat_reg    <= 1'b0;
        end else begin
            if (flush) begin
                row_cnt_reg <= '0;
                acc_reg     <= '0;
            end else if (accept) begin
                if (row_cnt_reg == '0) begin
                    acc_reg    <= row_sum;
                    relu_q_reg <= relu_en;
                end else begin
                    acc_reg    <= final_sum;
                end
                row_cnt_reg <= last_row ? '0 : row_cnt_reg + 1'b1;
            end

            if (accept && last_row) begin
                out_valid_reg  <= 1'b1;
                out_result_reg <= load_val;
                out_sat_reg    <= load_sat;
            end else if (out_valid_reg && bus.out_ready) begin
                out_valid_reg  <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready_int;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_result = out_result_reg;
    assign bus.out_sat    = out_sat_reg;
endmodule

// File: tb/tb_conv_window_mac.sv
// Directed bench: four engine variants (unsigned/signed x 25/16-bit result) share one
// stimulus stream; a vector table plus backpressure, flush and reset sequences.
module tb_conv_window_mac;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        relu_en;
    logic        in_valid;
    logic [31:0] in_data;
    logic [31:0] in_kern;
    logic        out_ready;

    int tests  = 0;
    int fails  = 0;
    int stalls = 0;

    always #5 clk = ~clk;

    conv_window_mac_if #(.DATA_W(8), .K(4), .OUT_W(25)) if_u25 ();
    conv_window_mac_if #(.DATA_W(8), .K(4), .OUT_W(25)) if_s25 ();
    conv_window_mac_if #(.DATA_W(8), .K(4), .OUT_W(16)) if_u16 ();
    conv_window_mac_if #(.DATA_W(8), .K(4), .OUT_W(16)) if_s16 ();

    assign if_u25.in_valid = in_valid;  assign if_u25.in_data = in_data;
    assign if_u25.in_kern  = in_kern;   assign if_u25.out_ready = out_ready;
    assign if_s25.in_valid = in_valid;  assign if_s25.in_data = in_data;
    assign if_s25.in_kern  = in_kern;   assign if_s25.out_ready = out_ready;
    assign if_u16.in_valid = in_valid;  assign if_u16.in_data = in_data;
    assign if_u16.in_kern  = in_kern;   assign if_u16.out_ready = out_ready;
    assign if_s16.in_valid = in_valid;  assign if_s16.in_data = in_data;
    assign if_s16.in_kern  = in_kern;   assign if_s16.out_ready = out_ready;

    conv_window_mac #(.DATA_W(8), .K(4), .OUT_W(25), .SIGNED_MODE(0)) u_u25 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .relu_en(relu_en), .bus(if_u25.slave));
    conv_window_mac #(.DATA_W(8), .K(4), .OUT_W(25), .SIGNED_MODE(1)) u_s25 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .relu_en(relu_en), .bus(if_s25.slave));
    conv_window_mac #(.DATA_W(8), .K(4), .OUT_W(16), .SIGNED_MODE(0)) u_u16 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .relu_en(relu_en), .bus(if_u16.slave));
    conv_window_mac #(.DATA_W(8), .K(4), .OUT_W(16), .SIGNED_MODE(1)) u_s16 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .relu_en(relu_en), .bus(if_s16.slave));

    // Uniform windows use d/k for every element; ramp windows use data = d+4r+j, kern = k*(j+1).
    typedef struct {
        logic [7:0] d;
        logic [7:0] k;
        bit         ramp;
        bit         relu;
        int         e_u25;
        int         e_s25;
        int         e_u16;
        bit         s_u16;
        int         e_s16;
        bit         s_s16;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_data(input logic [7:0] d, input bit ramp, input int r);
        logic [31:0] v;
        logic [7:0]  e;
        v = '0;
        for (int j = 0; j < 4; j++) begin
            e = ramp ? d + 8'(4*r + j) : d;
            v[j*8 +: 8] = e;
        end
        return v;
    endfunction

    function automatic logic [31:0] mk_kern(input logic [7:0] k, input bit ramp);
        logic [31:0] v;
        logic [7:0]  e;
        v = '0;
        for (int j = 0; j < 4; j++) begin
            e = ramp ? k * 8'(j + 1) : k;
            v[j*8 +: 8] = e;
        end
        return v;
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that accepted the beat.
    task automatic send_row(input logic [7:0] d, input logic [7:0] k, input bit ramp,
                            input bit relu, input int r);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = mk_data(d, ramp, r);
        in_kern  = mk_kern(k, ramp);
        relu_en  = relu;
        #1;
        while (!if_s25.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
            stalls++;
        end
        if (n >= 20) chk("row_accept_timeout", 32'(n), 32'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_window(input logic [7:0] d, input logic [7:0] k, input bit ramp,
                               input bit relu);
        for (int r = 0; r < 4; r++) send_row(d, k, ramp, relu, r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_all(input int idx);
        int e;
        logic [24:0] e25;
        logic [15:0] e16;
        $display("[TB] vec %0d d=%02h k=%02h ramp=%0d relu=%0d -> u25=%0d s25=%0d u16=%0d s16=%0d",
                 idx, vecs[idx].d, vecs[idx].k, vecs[idx].ramp, vecs[idx].relu,
                 if_u25.out_result, $signed(if_s25.out_result), if_u16.out_result,
                 $signed(if_s16.out_result));
        chk($sformatf("vec%0d_valid", idx), 32'(if_s25.out_valid), 32'(1));
        e = vecs[idx].e_u25; e25 = e[24:0];
        chk($sformatf("vec%0d_u25", idx), 32'(if_u25.out_result), 32'(e25));
        chk($sformatf("vec%0d_u25_sat", idx), 32'(if_u25.out_sat), 32'(0));
        e = vecs[idx].e_s25; e25 = e[24:0];
        chk($sformatf("vec%0d_s25", idx), 32'(if_s25.out_result), 32'(e25));
        chk($sformatf("vec%0d_s25_sat", idx), 32'(if_s25.out_sat), 32'(0));
        e = vecs[idx].e_u16; e16 = e[15:0];
        chk($sformatf("vec%0d_u16", idx), 32'(if_u16.out_result), 32'(e16));
        chk($sformatf("vec%0d_u16_sat", idx), 32'(if_u16.out_sat), 32'(vecs[idx].s_u16));
        e = vecs[idx].e_s16; e16 = e[15:0];
        chk($sformatf("vec%0d_s16", idx), 32'(if_s16.out_result), 32'(e16));
        chk($sformatf("vec%0d_s16_sat", idx), 32'(if_s16.out_sat), 32'(vecs[idx].s_s16));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int st0;
        int e;
        logic [24:0] e25;

        //          d      k      ramp relu  u25      s25      u16    s   s16     s
        vecs[0] = '{8'hFF, 8'hFF, 0,   0,    1040400, 16,      65535, 1,  16,     0};
        vecs[1] = '{8'h80, 8'h7F, 0,   0,    260096,  -260096, 65535, 1,  -32768, 1};
        vecs[2] = '{8'h80, 8'h7F, 0,   1,    260096,  0,       65535, 1,  0,      0};
        vecs[3] = '{8'h7F, 8'h7F, 0,   0,    258064,  258064,  65535, 1,  32767,  1};
        vecs[4] = '{8'h7F, 8'h7F, 0,   1,    258064,  258064,  65535, 1,  32767,  1};
        vecs[5] = '{8'h01, 8'hFF, 1,   0,    34456,   -360,    34456, 0,  -360,   0};
        vecs[6] = '{8'h01, 8'hFF, 1,   1,    34456,   0,       34456, 0,  0,      0};
        vecs[7] = '{8'h03, 8'h05, 0,   1,    240,     240,     240,   0,  240,    0};
        vecs[8] = '{8'hFF, 8'h01, 0,   0,    4080,    -16,     4080,  0,  -16,    0};

        rst_n = 1'b0; flush = 1'b0; relu_en = 1'b0;
        in_valid = 1'b0; in_data = '0; in_kern = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] reset state");
        chk("rst_valid", 32'(if_s25.out_valid), 32'(0));
        chk("rst_result", 32'(if_s25.out_result), 32'(0));
        chk("rst_sat", 32'(if_s16.out_sat), 32'(0));
        chk("rst_valid_u", 32'(if_u25.out_valid), 32'(0));
        chk("rst_in_ready", 32'(if_s25.in_ready), 32'(1));
        rst_n = 1'b1;
        idle(1);

        // Back-to-back windows with out_ready high: no stalls, result one cycle after row 3.
        st0 = stalls;
        for (int i = 0; i < 9; i++) begin
            send_window(vecs[i].d, vecs[i].k, vecs[i].ramp, vecs[i].relu);
            check_all(i);
        end
        chk("stream_no_stall", 32'(stalls - st0), 32'(0));
        idle(1);
        $display("[TB] drain after stream");
        chk("drain_valid", 32'(if_s25.out_valid), 32'(0));

        // Backpressure: result 1 held while rows 0-2 of window 2 go in; row 3 stalls.
        out_ready = 1'b0;
        send_window(8'h03, 8'h05, 0, 0);
        $display("[TB] bp result1 = %0d", if_s25.out_result);
        chk("bp_r1_valid", 32'(if_s25.out_valid), 32'(1));
        chk("bp_r1", 32'(if_s25.out_result), 32'(240));
        st0 = stalls;
        for (int r = 0; r < 3; r++) send_row(8'h80, 8'h7F, 0, 0, r);
        chk("bp_rows_no_stall", 32'(stalls - st0), 32'(0));
        in_valid = 1'b1;
        in_data  = mk_data(8'h80, 0, 3);
        in_kern  = mk_kern(8'h7F, 0);
        #1;
        chk("bp_row3_blocked", 32'(if_s25.in_ready), 32'(0));
        idle(2);
        $display("[TB] bp hold result = %0d ready=%0d", if_s25.out_result, if_s25.in_ready);
        chk("bp_hold_ready", 32'(if_s25.in_ready), 32'(0));
        chk("bp_hold_result", 32'(if_s25.out_result), 32'(240));
        chk("bp_hold_valid", 32'(if_s25.out_valid), 32'(1));
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", 32'(if_s25.in_ready), 32'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = -260096; e25 = e[24:0];
        $display("[TB] bp result2 = %0d", $signed(if_s25.out_result));
        chk("bp_r2_valid", 32'(if_s25.out_valid), 32'(1));
        chk("bp_r2", 32'(if_s25.out_result), 32'(e25));
        chk("bp_r2_s16", 32'(if_s16.out_result), 32'(16'h8000));
        chk("bp_r2_s16_sat", 32'(if_s16.out_sat), 32'(1));
        idle(1);
        chk("bp_consumed", 32'(if_s25.out_valid), 32'(0));

        // Flush after two rows of window A; the beat offered during flush is dropped.
        send_row(8'h7F, 8'h7F, 0, 0, 0);
        send_row(8'h7F, 8'h7F, 0, 0, 1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = mk_data(8'h7F, 0, 2);
        in_kern  = mk_kern(8'h7F, 0);
        #1;
        chk("flush_ready_low", 32'(if_s25.in_ready), 32'(0));
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_no_valid", 32'(if_s25.out_valid), 32'(0));
        idle(2);
        for (int r = 0; r < 4; r++) begin
            send_row(8'h03, 8'h05, 0, 0, r);
            if (r < 3) begin
                chk($sformatf("flush_gap%0d_valid", r), 32'(if_s25.out_valid), 32'(0));
                idle(2);
            end
        end
        $display("[TB] flush window B = %0d", if_s25.out_result);
        chk("flush_b_valid", 32'(if_s25.out_valid), 32'(1));
        chk("flush_b_s25", 32'(if_s25.out_result), 32'(240));
        chk("flush_b_u16", 32'(if_u16.out_result), 32'(240));
        idle(1);

        // Held result survives a flush, then reset clears it and a partial window.
        out_ready = 1'b0;
        send_window(8'h7F, 8'h7F, 0, 0);
        chk("hold_valid", 32'(if_s25.out_valid), 32'(1));
        chk("hold_result", 32'(if_s25.out_result), 32'(258064));
        send_row(8'h80, 8'h7F, 0, 0, 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        $display("[TB] flush while held: valid=%0d result=%0d", if_s25.out_valid,
                 if_s25.out_result);
        chk("flush_keeps_valid", 32'(if_s25.out_valid), 32'(1));
        chk("flush_keeps_result", 32'(if_s25.out_result), 32'(258064));
        chk("flush_keeps_sat", 32'(if_s16.out_sat), 32'(1));
        send_row(8'h80, 8'h7F, 0, 0, 0);
        send_row(8'h80, 8'h7F, 0, 0, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        $display("[TB] reset while held: valid=%0d result=%0d", if_s25.out_valid,
                 if_s25.out_result);
        chk("rst2_valid", 32'(if_s25.out_valid), 32'(0));
        chk("rst2_result", 32'(if_s25.out_result), 32'(0));
        chk("rst2_sat", 32'(if_s16.out_sat), 32'(0));
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_window(8'h03, 8'h05, 0, 0);
        $display("[TB] after reset window = %0d", if_s25.out_result);
        chk("rst2_window", 32'(if_s25.out_result), 32'(240));
        chk("rst2_window_valid", 32'(if_s25.out_valid), 32'(1));
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
